// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Shares one single-port word memory between an instruction-fetch |
// |            requester (i_*) and a data load/store requester (d_*). One      |
// |            transaction at a time, req/ack handshake per requester, read    |
// |            data registered back to the requester that was served.          |
// | Ports    : clk, rst            - clock, synchronous active-high reset      |
// |            i_req/i_addr        - fetch request and word address            |
// |            i_ack/i_rdata       - fetch done pulse and registered data      |
// |            d_req/d_we/d_addr/  - data request, 1=store, address, store     |
// |            d_wdata               data                                      |
// |            d_ack/d_rdata       - data done pulse and registered load data  |
// |            mem_addr/mem_wdata/ - memory address, write data, write strobe, |
// |            mem_wr/mem_read       read enable                               |
// |            mem_rdata           - memory combinational read data            |
// |            busy                - a transaction is in flight                |
// |            owner               - 0=fetch, 1=data; current/last served      |
// | Config   : MEM_ARB_RR_EN defined -> round-robin on simultaneous requests;  |
// |            undefined -> fixed priority, data wins.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   // Counter only has to hold WAIT_CYC-1 down to 0.
   localparam int               CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_we;
   logic              any_req;
   logic              grant_d;

   assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
   // On a tie the requester that was not served last wins; owner resets to
   // fetch, so data takes the first tie after reset.
   assign grant_d = d_req & (~i_req | ~owner);
`else
   assign grant_d = d_req;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (any_req) state_nxt = S_ACCESS;
         S_ACCESS: if (cnt == '0) state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Request latch, wait counter and read-data capture. Inputs are only looked
   // at in IDLE, so a requester may drop req or change address after grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         owner     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner     <= grant_d;
                  lat_addr  <= grant_d ? d_addr : i_addr;
                  lat_wdata <= grant_d ? d_wdata : '0;
                  lat_we    <= grant_d & d_we;
                  cnt       <= CNT_LOAD;
               end
            end
            S_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (!lat_we) begin
                  if (owner) begin
                     d_rdata <= mem_rdata;
                  end else begin
                     i_rdata <= mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic. The write strobe is confined to the final ACCESS cycle so a
   // store commits exactly once; both strobes are masked while rst is high.
   always_comb begin
      busy      = (state != S_IDLE);
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_wr    = 1'b0;
      case (state)
         S_ACCESS: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_read  = ~lat_we & ~rst;
            mem_wr    = lat_we & (cnt == '0) & ~rst;
         end
         S_RESP: begin
            i_ack = ~owner;
            d_ack = owner;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                             |
// | Purpose  : Scoreboard bench for mem_port_arbiter with a 32x32 memory model |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int WC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [4:0]  i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [4:0]  d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        mem_read;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        owner;

   mem_port_arbiter #(.ADDR_W(5), .DATA_W(32), .WAIT_CYC(WC)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .mem_read(mem_read), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Physical memory seen by the DUT
   logic [31:0] mem [32];
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   typedef struct {
      bit          who;
      logic [31:0] i_rd;
      logic [31:0] d_rd;
      int          at;
   } exp_t;
   exp_t        q[$];
   logic [31:0] ref_mem [32];
   bit          m_owner = 1'b0;
   logic [31:0] m_i_rd = '0;
   logic [31:0] m_d_rd = '0;
   int          m_stores = 0;
   int          wr_seen = 0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever an ack appears
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_wr) wr_seen++;
         if (rst) chk("mem_wr_during_rst", {63'b0, mem_wr}, 64'd0);
         if (i_ack || d_ack) begin
            if (q.size() == 0) begin
               chk("unexpected_ack", {62'b0, d_ack, i_ack}, 64'd0);
            end else begin
               e = q.pop_front();
               chk("ack_who", {62'b0, d_ack, i_ack}, e.who ? 64'd2 : 64'd1);
               chk("ack_cycle", 64'(cyc), 64'(e.at));
               chk("ack_owner", {63'b0, owner}, {63'b0, e.who});
               chk("i_rdata", {32'b0, i_rdata}, {32'b0, e.i_rd});
               chk("d_rdata", {32'b0, d_rdata}, {32'b0, e.d_rd});
            end
         end
      end
   end

   // Issue one arbitration round; called #1 after an edge with the DUT idle.
   task automatic txn(input bit ui, input bit ud, input bit we, input logic [4:0] ia,
                      input logic [4:0] da, input logic [31:0] wd, input bit drop_i);
      int   c0, n, drop_i_at, drop_d_at, end_at;
      bit   first_d;
      bit   who_l[2];
      exp_t e;
      c0 = cyc; n = 0; drop_i_at = -1; drop_d_at = -1;
      i_req = ui; i_addr = ia; d_req = ud; d_we = we; d_addr = da; d_wdata = wd;
`ifdef MEM_ARB_RR_EN
      first_d = ud && (!ui || !m_owner);
`else
      first_d = ud;
`endif
      if (first_d)       begin who_l[n] = 1'b1; n++; end
      if (ui)            begin who_l[n] = 1'b0; n++; end
      if (ud && !first_d) begin who_l[n] = 1'b1; n++; end
      for (int k = 0; k < n; k++) begin
         if (who_l[k]) begin
            if (we) begin ref_mem[da] = wd; m_stores++; end
            else m_d_rd = ref_mem[da];
            drop_d_at = c0 + k*(WC+2) + WC + 2;
         end else begin
            m_i_rd = ref_mem[ia];
            drop_i_at = c0 + k*(WC+2) + WC + 2;
         end
         m_owner = who_l[k];
         e.who = who_l[k]; e.i_rd = m_i_rd; e.d_rd = m_d_rd;
         e.at = c0 + k*(WC+2) + WC + 1;
         q.push_back(e);
      end
      if (drop_i) drop_i_at = c0 + 1;
      end_at = c0 + n*(WC+2);
      while (cyc < end_at) begin
         @(posedge clk); #1;
         if (cyc == c0 + 1 && n == 1) begin
            // Inputs changing after grant must not disturb the transaction
            i_addr = 5'($urandom); d_addr = 5'($urandom);
            d_wdata = $urandom; d_we = ~d_we;
         end
         if (cyc == drop_i_at) i_req = 1'b0;
         if (cyc == drop_d_at) d_req = 1'b0;
      end
      if (drop_i) begin
         @(posedge clk); #1;
         chk("no_regrant_after_drop", {63'b0, busy}, 64'd0);
      end
   endtask

   // Store interrupted by reset during its final access cycle
   task automatic rst_store(input logic [4:0] a, input logic [31:0] wd);
      int c0;
      c0 = cyc;
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd;
      while (cyc < c0 + WC) begin @(posedge clk); #1; end
      rst = 1'b1; d_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_owner = 1'b0; m_i_rd = '0; m_d_rd = '0;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_owner", {63'b0, owner}, 64'd0);
      chk("rst_i_rdata", {32'b0, i_rdata}, 64'd0);
      chk("rst_d_rdata", {32'b0, d_rdata}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ui, ud;
      int r;
      for (int i = 0; i < 32; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[0] = 32'h00812020; ref_mem[0] = 32'h00812020;
      mem[7] = 32'h13572468; ref_mem[7] = 32'h13572468;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_acks", {62'b0, d_ack, i_ack}, 64'd0);
      chk("reset_rdata", {i_rdata, d_rdata}, 64'd0);
      chk("reset_owner", {63'b0, owner}, 64'd0);
      chk("reset_strobes", {62'b0, mem_wr, mem_read}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      txn(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);               // fetch of word 0
      txn(1'b0, 1'b1, 1'b1, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0);        // store to 5
      txn(1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 32'h0, 1'b0);               // load from 5
      txn(1'b1, 1'b1, 1'b0, 5'd3, 5'd9, 32'h0, 1'b0);               // simultaneous
      txn(1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 32'hA5A5F00D, 1'b0);        // tie, same word
      txn(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 32'h0, 1'b1);               // fetch req dropped
      rst_store(5'd7, 32'hCAFEF00D);                                // store killed by rst
      for (int t = 0; t < 4; t++) txn(1'b1, 1'b1, 1'b0, 5'(t), 5'(t + 8), 32'h0, 1'b0);

      for (int t = 0; t < 60; t++) begin
         r = $urandom_range(0, 11);
         if (r == 0) begin
            rst_store(5'($urandom), $urandom);
         end else begin
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1'b1;
            txn(ui, ud, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), $urandom,
                ui && !ud && ($urandom_range(0, 3) == 0));
         end
      end

      repeat (WC + 4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      chk("write_pulses", 64'(wr_seen), 64'(m_stores));
      for (int i = 0; i < 32; i++) chk("mem_contents", {32'b0, mem[i]}, {32'b0, ref_mem[i]});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
